// File: rtl/q_enc_sampler.sv
// Periodic snapshot/velocity controller for a bank of quadrature encoder counters.
// Streams {pos, vel, err} one channel per beat and sequences per-channel zeroing.
module q_enc_sampler #(
  parameter  int N_CH     = 4,
  parameter  int PERIOD_W = 24,
  localparam int CH_W     = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                 clock,
  input  logic                 sclr,
  input  logic                 run,
  input  logic [PERIOD_W-1:0]  period,
  input  logic [32*N_CH-1:0]   pos_in,
  input  logic [N_CH-1:0]      err_in,
  output logic [N_CH-1:0]      enc_sclr,
  output logic [N_CH-1:0]      enc_ena,
  input  logic                 zero_req,
  input  logic [CH_W-1:0]      zero_ch,
  output logic                 zero_ack,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [CH_W-1:0]      out_ch,
  output logic [31:0]          out_pos,
  output logic [31:0]          out_vel,
  output logic                 out_err,
  output logic                 out_last,
  output logic                 overrun
);

  typedef enum logic {S_IDLE = 1'b0, S_STREAM = 1'b1} state_t;

  localparam logic [CH_W-1:0] LAST_CH = CH_W'(N_CH - 1);

  state_t              r_state;
  logic [PERIOD_W-1:0] r_tmr;
  logic [CH_W-1:0]     r_ch;
  logic [31:0]         r_prev_pos [N_CH];
  logic [31:0]         r_snap_pos [N_CH];
  logic [31:0]         r_snap_vel [N_CH];
  logic [N_CH-1:0]     r_snap_err;
  logic                r_overrun;
  logic                r_zero_pend;
  logic [CH_W-1:0]     r_zero_ch;

  logic                w_tick;
  logic                w_zero_acc;
  logic                w_zero_in_range;
  logic [N_CH-1:0]     w_zero_mask;

  assign w_tick          = (period != {PERIOD_W{1'b0}}) && (r_tmr >= (period - PERIOD_W'(1)));
  // A request is blocked only while a real clear pulse is on the bus.
  assign w_zero_acc      = zero_req && !r_zero_pend && !sclr;
  assign w_zero_in_range = (32'(zero_ch) < 32'(N_CH));

  // Decode of the pending single-channel clear.
  always_comb begin
    w_zero_mask = {N_CH{1'b0}};
    if (r_zero_pend) begin
      w_zero_mask[r_zero_ch] = 1'b1;
    end else begin
      w_zero_mask = {N_CH{1'b0}};
    end
  end

  assign enc_sclr  = {N_CH{sclr}} | w_zero_mask;
  assign enc_ena   = {N_CH{run}};
  assign zero_ack  = w_zero_acc;
  assign out_valid = (r_state == S_STREAM);
  assign out_ch    = r_ch;
  assign out_pos   = r_snap_pos[r_ch];
  assign out_vel   = r_snap_vel[r_ch];
  assign out_err   = r_snap_err[r_ch];
  assign out_last  = (r_state == S_STREAM) && (r_ch == LAST_CH);
  assign overrun   = r_overrun;

  // Timer, snapshot/stream FSM and zeroing sequencer.
  always_ff @(posedge clock) begin
    if (sclr) begin
      r_state     <= S_IDLE;
      r_tmr       <= {PERIOD_W{1'b0}};
      r_ch        <= {CH_W{1'b0}};
      r_snap_err  <= {N_CH{1'b0}};
      r_overrun   <= 1'b0;
      r_zero_pend <= 1'b0;
      r_zero_ch   <= {CH_W{1'b0}};
      for (int k = 0; k < N_CH; k++) begin
        r_prev_pos[k] <= 32'd0;
        r_snap_pos[k] <= 32'd0;
        r_snap_vel[k] <= 32'd0;
      end
    end else begin
      if ((period == {PERIOD_W{1'b0}}) || w_tick) begin
        r_tmr <= {PERIOD_W{1'b0}};
      end else begin
        r_tmr <= r_tmr + PERIOD_W'(1);
      end

      r_zero_pend <= w_zero_acc && w_zero_in_range;
      if (w_zero_acc) begin
        r_zero_ch <= zero_ch;
      end

      case (r_state)
        S_IDLE: begin
          if (w_tick) begin
            for (int k = 0; k < N_CH; k++) begin
              r_snap_pos[k] <= pos_in[32*k +: 32];
              r_snap_vel[k] <= pos_in[32*k +: 32] - r_prev_pos[k];
              r_prev_pos[k] <= pos_in[32*k +: 32];
            end
            r_snap_err <= err_in;
            r_ch       <= {CH_W{1'b0}};
            r_state    <= S_STREAM;
          end
        end
        S_STREAM: begin
          if (w_tick) begin
            r_overrun <= 1'b1;
          end
          if (out_ready) begin
            if (r_ch == LAST_CH) begin
              r_state <= S_IDLE;
            end else begin
              r_ch <= r_ch + CH_W'(1);
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase

      // Placed last so the clear wins over a same-cycle snapshot update.
      if (r_zero_pend) begin
        r_prev_pos[r_zero_ch] <= 32'd0;
      end
    end
  end

endmodule
